// File: rtl/regfile_dual_pkg.sv
// Shared pipeline constants for the two-lane register file and hazard logic.
package regfile_dual_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned REG_ZERO = 0;

    // Program order of the two issue lanes; lane 2 holds the younger instruction.
    typedef enum logic {
        LANE_1 = 1'b0,
        LANE_2 = 1'b1
    } lane_e;

    localparam lane_e YOUNGER_LANE = LANE_2;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero register, write-through bypass, array data.
module regfile_rdport
    import regfile_dual_pkg::*;
#(
    parameter int unsigned WIDTH  = DATA_W,
    parameter int unsigned AWIDTH = ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic              reset_i,
    input  logic [AWIDTH-1:0] ra_i,
    input  logic [WIDTH-1:0]  arr_rd_i,
    input  logic              we1_i,
    input  logic [AWIDTH-1:0] wa1_i,
    input  logic [WIDTH-1:0]  wd1_i,
    input  logic              we2_i,
    input  logic [AWIDTH-1:0] wa2_i,
    input  logic [WIDTH-1:0]  wd2_i,
    output logic [WIDTH-1:0]  rd_o
);

    logic hit1;
    logic hit2;

    // Bypass hits are gated by the parameter so a disabled bypass reads the array only.
    assign hit1 = (BYPASS != 0) && we1_i && (wa1_i == ra_i);
    assign hit2 = (BYPASS != 0) && we2_i && (wa2_i == ra_i);

    // Priority: reset, zero register, younger lane, older lane, stored value.
    always_comb begin
        rd_o = '0;
        if (reset_i) begin
            rd_o = '0;
        end else if (ra_i == AWIDTH'(REG_ZERO)) begin
            rd_o = '0;
        end else if (hit2) begin
            rd_o = wd2_i;
        end else if (hit1) begin
            rd_o = wd1_i;
        end else begin
            rd_o = arr_rd_i;
        end
    end

endmodule

// File: rtl/regfile_dual.sv
// Dual-write, quad-read register file with optional same-cycle write-through.
module regfile_dual
    import regfile_dual_pkg::*;
#(
    parameter int unsigned WIDTH  = DATA_W,
    parameter int unsigned AWIDTH = ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwritew,
    input  logic [AWIDTH-1:0] writeregw,
    input  logic [WIDTH-1:0]  resultw,
    input  logic              regwritew2,
    input  logic [AWIDTH-1:0] writeregw2,
    input  logic [WIDTH-1:0]  resultw2,
    input  logic [AWIDTH-1:0] ra1,
    input  logic [AWIDTH-1:0] ra2,
    input  logic [AWIDTH-1:0] ra3,
    input  logic [AWIDTH-1:0] ra4,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic [WIDTH-1:0]  rd3,
    output logic [WIDTH-1:0]  rd4
);

    localparam int unsigned NREGS = 2 ** AWIDTH;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             we1;
    logic             we2;

    // Register 0 is never a write target, so it stays at its reset value of zero.
    assign we1 = regwritew  && (writeregw  != AWIDTH'(REG_ZERO));
    assign we2 = regwritew2 && (writeregw2 != AWIDTH'(REG_ZERO));

    // Older lane applied first so the younger lane wins a same-register conflict.
    always_comb begin
        regs_d = regs_q;
        if (we1) begin
            regs_d[writeregw] = resultw;
        end
        if (we2) begin
            regs_d[writeregw2] = resultw2;
        end
    end

    // Array update; reset clears every entry and drops that cycle's writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic [AWIDTH-1:0] ra_arr [4];
    logic [WIDTH-1:0]  rd_arr [4];

    assign ra_arr[0] = ra1;
    assign ra_arr[1] = ra2;
    assign ra_arr[2] = ra3;
    assign ra_arr[3] = ra4;

    assign rd1 = rd_arr[0];
    assign rd2 = rd_arr[1];
    assign rd3 = rd_arr[2];
    assign rd4 = rd_arr[3];

    // Four identical read ports sharing the writeback bypass sources.
    for (genvar k = 0; k < 4; k++) begin : g_rdport
        regfile_rdport #(
            .WIDTH  (WIDTH),
            .AWIDTH (AWIDTH),
            .BYPASS (BYPASS)
        ) u_rdport (
            .reset_i  (reset),
            .ra_i     (ra_arr[k]),
            .arr_rd_i (regs_q[ra_arr[k]]),
            .we1_i    (regwritew),
            .wa1_i    (writeregw),
            .wd1_i    (resultw),
            .we2_i    (regwritew2),
            .wa2_i    (writeregw2),
            .wd2_i    (resultw2),
            .rd_o     (rd_arr[k])
        );
    end

endmodule

// File: doc/regfile_dual.md
Name: regfile_dual

Overview:
- Dual-write, quad-read architectural register file for the two-lane (superscalar) MIPS pipeline.
- Sits directly downstream of the MEM/WB pipeline register and consumes its writeback outputs: lane 1 and lane 2 results, destination registers and regwrite enables.
- Its read ports feed the decode stage: rs/rt for lane 1 on ports 1/2, rs/rt for lane 2 on ports 3/4.
- Provides write-through bypass, so a value written in cycle N is readable combinationally in cycle N.

Parameters:
- WIDTH, 32, data width of each register.
- AWIDTH, 5, register address width; NREGS = 2**AWIDTH = 32.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return array contents only.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- regwritew  input  1  lane 1 write enable.
- writeregw  input  AWIDTH  lane 1 destination register.
- resultw  input  WIDTH  lane 1 write data (memtoreg mux output, external).
- regwritew2  input  1  lane 2 write enable.
- writeregw2  input  AWIDTH  lane 2 destination register.
- resultw2  input  WIDTH  lane 2 write data.
- ra1, ra2, ra3, ra4  input  AWIDTH each  read addresses (lane 1 rs/rt, lane 2 rs/rt).
- rd1, rd2, rd3, rd4  output  WIDTH each  read data, combinational.

Behaviour:
- Storage: array of NREGS x WIDTH flops. Register 0 is hardwired to 0: never written, always reads 0.
- Reset:
  - While reset=1, every entry is cleared to 0 at the rising edge and writes that cycle are discarded.
  - rd1..rd4 are forced to 0 while reset=1; bypass is disabled.
- Write, rising edge, reset=0:
  - If regwritew and writeregw!=0, reg[writeregw] <= resultw.
  - Same rule for lane 2.
  - Enables are honoured independently; disabled lanes leave the array untouched.
- Write conflict:
  - Both lanes enabled with writeregw==writeregw2 (nonzero): lane 2 wins, because lane 2 is the younger instruction in program order.
  - Lane 1 data is dropped.
- Read, combinational, zero latency. For each port k:
  - If rak==0, rdk = 0.
  - Else if BYPASS, regwritew2 and writeregw2==rak, rdk = resultw2.
  - Else if BYPASS, regwritew and writeregw==rak, rdk = resultw.
  - Else rdk = reg[rak].
  - Bypass priority matches write priority, so a bypassed read always equals the value visible after the edge.
- With BYPASS=0, a write in cycle N is visible from cycle N+1.
- Stalls: the upstream MEM/WB register holds its outputs during stallw. Repeated identical writes are idempotent, so no stall input is required.
- X-safety: enables that are 0 suppress writes regardless of address/data values. No reset-free flops.
- Reset mid-operation: pending writes in the reset cycle are lost. The first write after reset deassertion takes effect at the next rising edge.

Decomposition:
- Shared pipeline package holds:
  - WIDTH and AWIDTH constants.
  - REG_ZERO = 0.
  - Lane-order constant documenting that lane 2 is younger (also used by the hazard unit).
- One natural sub-module: regfile_rdport. It is combinational and instantiated 4 times; it implements the zero/bypass/array selection for one read port. The array and write logic stay in the top module.

Test Plan:
- Reset held 2 cycles after random writes -> all 4 read ports return 0 for every address 0..31; deassert, then read r5 -> 0.
- Lane 1 writes r8=0x12345678, lane 2 writes r9=0xDEADBEEF in the same cycle -> same cycle with BYPASS=1: rd1(ra1=8)=0x12345678, rd3(ra3=9)=0xDEADBEEF; next cycle with enables low: same values from the array.
- Both lanes write r10 (lane 1 0x1111, lane 2 0x2222) -> bypass read returns 0x2222; after the edge reg[10]=0x2222.
- Write r0=0xFFFFFFFF on both lanes -> rd on ra=0 stays 0 in that cycle and all later cycles.
- regwritew=0 with writeregw=3, resultw=0xABCD -> r3 keeps its prior value 0x0; then reset asserted in the same cycle as a lane 2 write r4=0x77 -> r4 reads 0 after reset.
- BYPASS=0 instance: write r7=0x55 -> rd2(ra2=7) shows the old value 0 in cycle N and 0x55 in cycle N+1.
